// File: rtl/ascon_enc_sched.sv
// Sequencing controller for the shared-round ASCON-128 encryption datapath.
// Optional feature: define ASCON_SCHED_ABORT_EN to add the abort input.
module ascon_enc_sched #(
  parameter int unsigned PA_ROUNDS = 12,
  parameter int unsigned PB_ROUNDS = 6,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ASCON_SCHED_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] ad_blocks,
  input  logic [CNT_W-1:0] pt_blocks,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             sel_init,
  output logic             perm_en,
  output logic [3:0]       round_idx,
  output logic             key_init,
  output logic             dom_sep,
  output logic             key_fin,
  output logic             tag_xor,
  output logic             busy,
  output logic             done
);

  localparam int unsigned RND_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_AD_WAIT, S_AD_PERM, S_DSEP,
    S_PT_WAIT, S_PT_PERM, S_FIN_PERM, S_DONE
  } state_t;

  state_t             state, state_d;
  logic [RND_W-1:0]   rnd_cnt, rnd_d;
  logic [CNT_W-1:0]   ad_cnt, ad_cnt_d, pt_cnt, pt_cnt_d;
  logic [CNT_W-1:0]   ad_total, ad_total_d, pt_total, pt_total_d;
  logic               abort_act;
  logic               rnd_last_a, rnd_last_b;

`ifdef ASCON_SCHED_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  assign rnd_last_a = (rnd_cnt == RND_W'(PA_ROUNDS - 1));
  assign rnd_last_b = (rnd_cnt == RND_W'(PB_ROUNDS - 1));

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rnd_cnt  <= '0;
      ad_cnt   <= '0;
      pt_cnt   <= '0;
      ad_total <= '0;
      pt_total <= '0;
    end else begin
      state    <= state_d;
      rnd_cnt  <= rnd_d;
      ad_cnt   <= ad_cnt_d;
      pt_cnt   <= pt_cnt_d;
      ad_total <= ad_total_d;
      pt_total <= pt_total_d;
    end
  end

  // Next-state, counter updates and strobes
  always_comb begin
    state_d    = state;
    rnd_d      = rnd_cnt;
    ad_cnt_d   = ad_cnt;
    pt_cnt_d   = pt_cnt;
    ad_total_d = ad_total;
    pt_total_d = pt_total;
    blk_ready  = 1'b0;
    sel_init   = 1'b0;
    perm_en    = 1'b0;
    round_idx  = '0;
    key_init   = 1'b0;
    dom_sep    = 1'b0;
    key_fin    = 1'b0;
    tag_xor    = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start) begin
          sel_init   = 1'b1;
          ad_total_d = ad_blocks;
          pt_total_d = (pt_blocks == '0) ? CNT_W'(1) : pt_blocks;
          ad_cnt_d   = '0;
          pt_cnt_d   = '0;
          rnd_d      = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        perm_en   = 1'b1;
        round_idx = rnd_cnt;
        rnd_d     = rnd_cnt + RND_W'(1);
        if (rnd_last_a) begin
          key_init = 1'b1;
          rnd_d    = '0;
          state_d  = (ad_total != '0) ? S_AD_WAIT : S_DSEP;
        end
      end
      S_AD_WAIT: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          ad_cnt_d = ad_cnt + CNT_W'(1);
          state_d  = S_AD_PERM;
        end
      end
      S_AD_PERM: begin
        perm_en   = 1'b1;
        round_idx = rnd_cnt + RND_W'(PA_ROUNDS - PB_ROUNDS);
        rnd_d     = rnd_cnt + RND_W'(1);
        if (rnd_last_b) begin
          rnd_d   = '0;
          state_d = (ad_cnt == ad_total) ? S_DSEP : S_AD_WAIT;
        end
      end
      S_DSEP: begin
        dom_sep = 1'b1;
        state_d = S_PT_WAIT;
      end
      S_PT_WAIT: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          pt_cnt_d = pt_cnt + CNT_W'(1);
          if (pt_cnt + CNT_W'(1) == pt_total) begin
            key_fin = 1'b1;
            state_d = S_FIN_PERM;
          end else begin
            state_d = S_PT_PERM;
          end
        end
      end
      S_PT_PERM: begin
        perm_en   = 1'b1;
        round_idx = rnd_cnt + RND_W'(PA_ROUNDS - PB_ROUNDS);
        rnd_d     = rnd_cnt + RND_W'(1);
        if (rnd_last_b) begin
          rnd_d   = '0;
          state_d = S_PT_WAIT;
        end
      end
      S_FIN_PERM: begin
        perm_en   = 1'b1;
        round_idx = rnd_cnt;
        rnd_d     = rnd_cnt + RND_W'(1);
        if (rnd_last_a) begin
          tag_xor = 1'b1;
          rnd_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort (and reset) silence every strobe; abort also wins over start in IDLE
    if (rst || abort_act) begin
      blk_ready = 1'b0;
      sel_init  = 1'b0;
      perm_en   = 1'b0;
      round_idx = '0;
      key_init  = 1'b0;
      dom_sep   = 1'b0;
      key_fin   = 1'b0;
      tag_xor   = 1'b0;
      done      = 1'b0;
    end
    if (abort_act) begin
      state_d = S_IDLE;
      rnd_d   = '0;
    end
  end

endmodule

// File: tb/tb_ascon_enc_sched.sv
// Self-checking bench for ascon_enc_sched: per-cycle trace built from phase rules.
// Honours ASCON_SCHED_ABORT_EN when the design is built with it.
module tb_ascon_enc_sched;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
`ifdef ASCON_SCHED_ABORT_EN
  logic             abort;
`endif
  logic             start;
  logic [CNT_W-1:0] ad_blocks, pt_blocks;
  logic             blk_valid;
  logic             blk_ready, sel_init, perm_en, key_init, dom_sep;
  logic             key_fin, tag_xor, busy, done;
  logic [3:0]       round_idx;

  int checks   = 0;
  int failures = 0;

  // Observed vector: sel,perm,idx[3:0],key_init,dom_sep,key_fin,tag_xor,ready,busy,done
  logic [12:0] obs;
  assign obs = {sel_init, perm_en, round_idx, key_init, dom_sep, key_fin,
                tag_xor, blk_ready, busy, done};

  logic [12:0] eq[$];
  bit          vq[$];
  int          ad_stall[8];
  int          pt_stall[8];

  ascon_enc_sched #(.PA_ROUNDS(12), .PB_ROUNDS(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
`ifdef ASCON_SCHED_ABORT_EN
    .abort(abort),
`endif
    .start(start), .ad_blocks(ad_blocks), .pt_blocks(pt_blocks),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .sel_init(sel_init),
    .perm_en(perm_en), .round_idx(round_idx), .key_init(key_init),
    .dom_sep(dom_sep), .key_fin(key_fin), .tag_xor(tag_xor),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(bit si, bit pe, int ri, bit ki, bit ds,
                                     bit kf, bit tx, bit br, bit bu, bit dn);
    logic [3:0] r4;
    r4 = 4'(ri);
    return {si, pe, r4, ki, ds, kf, tx, br, bu, dn};
  endfunction

  // Expected trace of one message: phase by phase, with planned upstream stalls
  task automatic build(int a, int p);
    int pe;
    eq.delete(); vq.delete();
    eq.push_back(mk(1,0,0,0,0,0,0,0,0,0)); vq.push_back(1'b0);
    for (int r = 0; r < 12; r++) begin
      eq.push_back(mk(0,1,r,r==11,0,0,0,0,1,0)); vq.push_back(1'($urandom_range(0,1)));
    end
    for (int i = 0; i < a; i++) begin
      for (int s = 0; s < ad_stall[i]; s++) begin
        eq.push_back(mk(0,0,0,0,0,0,0,1,1,0)); vq.push_back(1'b0);
      end
      eq.push_back(mk(0,0,0,0,0,0,0,1,1,0)); vq.push_back(1'b1);
      for (int r = 0; r < 6; r++) begin
        eq.push_back(mk(0,1,6+r,0,0,0,0,0,1,0)); vq.push_back(1'($urandom_range(0,1)));
      end
    end
    eq.push_back(mk(0,0,0,0,1,0,0,0,1,0)); vq.push_back(1'($urandom_range(0,1)));
    pe = (p == 0) ? 1 : p;
    for (int j = 0; j < pe; j++) begin
      for (int s = 0; s < pt_stall[j]; s++) begin
        eq.push_back(mk(0,0,0,0,0,0,0,1,1,0)); vq.push_back(1'b0);
      end
      eq.push_back(mk(0,0,0,0,0,j==pe-1,0,1,1,0)); vq.push_back(1'b1);
      if (j != pe-1)
        for (int r = 0; r < 6; r++) begin
          eq.push_back(mk(0,1,6+r,0,0,0,0,0,1,0)); vq.push_back(1'($urandom_range(0,1)));
        end
    end
    for (int r = 0; r < 12; r++) begin
      eq.push_back(mk(0,1,r,0,0,0,r==11,0,1,0)); vq.push_back(1'($urandom_range(0,1)));
    end
    eq.push_back(mk(0,0,0,0,0,0,0,0,1,1)); vq.push_back(1'($urandom_range(0,1)));
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 8; i++) begin ad_stall[i] = 0; pt_stall[i] = 0; end
  endtask

  task automatic check_idle(string name, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0; blk_valid = 1'($urandom_range(0,1));
      #4;
      checks++;
      if (obs !== 13'h0) begin
        failures++;
        $display("FAIL %s idle cycle %0d got=%h exp=%h", name, k, obs, 13'h0);
      end
    end
  endtask

  // Drive one message cycle by cycle; kill_at>=0 asserts rst (or abort) at that cycle
  task automatic run_msg(string name, int a, int p, bit hold, int kill_at,
                         bit kill_abort, output int done_cyc, output int perm_cyc);
    done_cyc = -1; perm_cyc = 0;
    build(a, p);
    for (int idx = 0; idx < eq.size(); idx++) begin
      @(posedge clk); #1;
      start     = (idx == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom_range(0,1)));
      blk_valid = vq[idx];
      ad_blocks = (idx == 0) ? CNT_W'(a) : CNT_W'($urandom);
      pt_blocks = (idx == 0) ? CNT_W'(p) : CNT_W'($urandom);
      if (idx == kill_at) begin
        if (kill_abort) begin
`ifdef ASCON_SCHED_ABORT_EN
          abort = 1'b1;
`endif
        end else rst = 1'b1;
      end
      #4;
      if (idx == kill_at) begin
        if (kill_abort) begin
          checks++;
          if (obs !== mk(0,0,0,0,0,0,0,0,1,0)) begin
            failures++;
            $display("FAIL %s abort-cycle strobes got=%h exp=%h", name, obs,
                     mk(0,0,0,0,0,0,0,0,1,0));
          end
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
`ifdef ASCON_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        #4;
        checks++;
        if (obs !== 13'h0) begin
          failures++;
          $display("FAIL %s after-kill got=%h exp=%h", name, obs, 13'h0);
        end
        check_idle({name, "_postkill"}, 3);
        return;
      end
      checks++;
      if (obs !== eq[idx]) begin
        failures++;
        $display("FAIL %s cycle %0d got=%h exp=%h", name, idx, obs, eq[idx]);
      end
      if (obs[0] === 1'b1 && done_cyc < 0) done_cyc = idx;
      if (obs[11] === 1'b1) perm_cyc++;
    end
  endtask

  task automatic expect_int(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; blk_valid = 1'b0; ad_blocks = '0; pt_blocks = '0;
`ifdef ASCON_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #4;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 13'h0);
    end
    check_idle("reset_idle", 2);
  endtask

  task automatic test_basic();
    int dc, pc;
    clear_stalls();
    run_msg("a1p1", 1, 1, 0, -1, 0, dc, pc);
    expect_int("a1p1_done_cycle", dc, 34);
    expect_int("a1p1_perm_cycles", pc, 30);
    check_idle("a1p1_idle", 1);
    run_msg("a0p1", 0, 1, 0, -1, 0, dc, pc);
    expect_int("a0p1_done_cycle", dc, 27);
    check_idle("a0p1_idle", 1);
    run_msg("a0p0", 0, 0, 0, -1, 0, dc, pc);
    expect_int("a0p0_done_cycle", dc, 27);
    check_idle("a0p0_idle", 1);
  endtask

  task automatic test_stall();
    int dc, pc;
    clear_stalls();
    pt_stall[1] = 5;
    run_msg("a2p3_stall", 2, 3, 0, -1, 0, dc, pc);
    expect_int("a2p3_done_cycle", dc, 60);
    check_idle("a2p3_idle", 1);
  endtask

  task automatic test_random();
    int dc, pc, a, p, stalls;
    for (int it = 0; it < 8; it++) begin
      clear_stalls();
      a = $urandom_range(0, 3);
      p = $urandom_range(0, 4);
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
        ad_stall[i] = (i < a) ? $urandom_range(0, 3) : 0;
        pt_stall[i] = (i < ((p == 0) ? 1 : p)) ? $urandom_range(0, 3) : 0;
        stalls += ad_stall[i] + pt_stall[i];
      end
      run_msg("random", a, p, 0, -1, 0, dc, pc);
      expect_int("random_done_cycle", dc, 20 + 7*a + 7*((p == 0) ? 1 : p) + stalls);
      check_idle("random_idle", 1);
    end
  endtask

  task automatic test_reset_mid();
    int dc, pc;
    clear_stalls();
    run_msg("rst_fin", 1, 1, 0, 29, 0, dc, pc);
    run_msg("rst_after", 1, 1, 0, -1, 0, dc, pc);
    expect_int("rst_after_done_cycle", dc, 34);
    check_idle("rst_after_idle", 1);
  endtask

  task automatic test_back_to_back();
    int dc, pc;
    clear_stalls();
    run_msg("held_first", 1, 1, 1, -1, 0, dc, pc);
    expect_int("held_first_done_cycle", dc, 34);
    run_msg("held_second", 0, 2, 0, -1, 0, dc, pc);
    expect_int("held_second_done_cycle", dc, 34);
    check_idle("held_idle", 1);
  endtask

`ifdef ASCON_SCHED_ABORT_EN
  task automatic test_abort();
    int dc, pc;
    clear_stalls();
    run_msg("abort_ad", 1, 1, 0, 15, 1, dc, pc);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; #4;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL abort_vs_start got=%h exp=%h", obs, 13'h0);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; #4;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL abort_vs_start_next got=%h exp=%h", obs, 13'h0);
    end
    run_msg("abort_restart", 1, 1, 0, -1, 0, dc, pc);
    expect_int("abort_restart_done_cycle", dc, 34);
    check_idle("abort_idle", 1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_reset_mid();
    test_back_to_back();
`ifdef ASCON_SCHED_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_enc_sched.md
# ascon_enc_sched

Sequencing controller for the ASCON-128 encryption datapath, with one round unit shared across all phases. It replaces the fixed AD → PT → finalization chain with one state register and one single-round permutation unit, driven for the correct number of rounds per phase. The block issues absorb handshakes, round-constant indices, and key/domain-separation XOR strobes. The datapath register file and round logic sit beside it in the encrypt top level.

## Interface
Parameters:
- PA_ROUNDS, 12, rounds of p^a (initialization, finalization)
- PB_ROUNDS, 6, rounds of p^b (per AD/PT block)
- CNT_W, 32, width of block counters

Ports:
- clk  in  1  clock, single domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  message start pulse, sampled only in IDLE
- ad_blocks  in  CNT_W  padded 64-bit AD block count, latched at start; 0 = no AD
- pt_blocks  in  CNT_W  padded PT block count, latched at start; 0 treated as 1
- blk_valid  in  1  upstream AD/PT block present
- blk_ready  out  1  block absorbed when blk_valid & blk_ready
- sel_init  out  1  load state ← IV‖K‖N
- perm_en  out  1  apply one round this cycle
- round_idx  out  4  round-constant index; 0 when perm_en=0
- key_init  out  1  XOR 0‖K into state after the round (end of init)
- dom_sep  out  1  XOR 1 into state LSB
- key_fin  out  1  XOR K into x1‖x2 after absorbing the last PT block
- tag_xor  out  1  tag = x3‖x4 ^ K valid after this round
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Reset value of every output: 0; FSM in IDLE; counters cleared.
- IDLE: if start=1, then sel_init=1, latch counts, go to INIT. Otherwise stay.
- INIT: perm_en=1 for PA_ROUNDS cycles, round_idx 0..11. The last cycle also sets key_init=1. Next state: AD_WAIT if ad_blocks≠0, else DSEP.
- AD_WAIT: blk_ready=1. On handshake, the datapath XORs the block into x0, ad_cnt++, and the FSM goes to AD_PERM.
- AD_PERM: perm_en=1 for PB_ROUNDS cycles, round_idx 6..11. On the last cycle, go to AD_WAIT if ad_cnt<ad_blocks, else DSEP.
- DSEP: dom_sep=1 for one cycle, then go to PT_WAIT.
- PT_WAIT: blk_ready=1. On handshake, pt_cnt++. If this is the last block, set key_fin=1 in the same cycle and go to FIN_PERM. Otherwise go to PT_PERM.
- PT_PERM: as AD_PERM, then return to PT_WAIT.
- FIN_PERM: perm_en=1 for PA_ROUNDS cycles, round_idx 0..11. The last cycle also sets tag_xor=1. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Round counter: 4 bits, wraps per phase, never exceeds 11.
- Block counters: CNT_W bits, compared for equality; no wrap is possible within a message.
- start outside IDLE: ignored.
- blk_valid outside the WAIT states: ignored; blk_ready stays 0.
- rst mid-message: IDLE on the next edge, all outputs 0, and no done pulse.

## Timing
- One state transition per clock. Strobes are combinational from state and counters, and are held for exactly the stated cycles.
- blk_ready can be high in the same cycle blk_valid rises. An absorb happens in the cycle where both are high.
- Stall: each cycle blk_valid=0 in a WAIT state adds one cycle of latency.
- Zero-stall latency: with start at cycle 0, done asserts at cycle 20 + 7·a + 7·p (a = ad_blocks, p = max(pt_blocks, 1)).
- A new start is accepted in the cycle after done.

## Configuration
- ASCON_SCHED_ABORT_EN defined: adds port abort (in, 1).
  - abort=1 in any non-IDLE state sends the FSM to IDLE at the next edge.
  - Strobes are suppressed that cycle, and done is not asserted.
  - If abort and start coincide in IDLE, abort wins and start is ignored.
- Macro undefined: no abort port. A message runs to DONE unless rst is asserted.

## Test plan
- a=1, p=1, blk_valid tied 1, start at cycle 0:
  - sel_init at cycle 0; key_init at cycle 12.
  - blk_ready at cycles 13 and 21; dom_sep at cycle 20.
  - key_fin at cycle 21; tag_xor at cycle 33; done at cycle 34.
  - 30 perm_en cycles in total.
- a=0, p=1: no AD handshake, dom_sep at cycle 13, done at cycle 27. With pt_blocks=0, the identical trace.
- a=2, p=3, blk_valid low for 5 cycles in the second PT_WAIT: 3 blk_ready handshakes in PT, done at cycle 55+5=60. Check round_idx is 6..11 in every PT_PERM.
- Reset: rst=1 in cycle 8 of FIN_PERM → next cycle busy=0, all strobes 0, no done. A following message completes normally.
- start held high through a whole message: only one message runs, and a new one begins the cycle after done.
- With ASCON_SCHED_ABORT_EN: abort in AD_PERM → IDLE next cycle, done stays 0, and a restart behaves as in the first scenario.
